// File: rtl/pri_req_pkg.sv
// Shared types and helpers for the pri_req_latch request-capture/grant stage.
package pri_req_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    localparam int N_DEF = 4;
    localparam int MAX_N = 32;

    // Callers size-cast the result down to their own request width.
    function automatic logic [MAX_N-1:0] onehot(input int unsigned idx);
        return MAX_N'(1) << idx;
    endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Highest-set-bit encoder: bit N-1 wins; all-zero input yields idx 0 with any=0.
module prio_enc_comb #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pri_req_latch.sv
// Latches request pulses into a pending register and grants the highest pending index
// over a valid/ready handshake. Define PRI_REQ_EDGE_EN to capture only rising edges of req.
module pri_req_latch
    import pri_req_pkg::*;
#(
    parameter  int N = N_DEF,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] pending,
    output logic         overflow
);

    state_t       state, state_next;
    logic [N-1:0] sample, cap, clr, pending_next;
    logic [W-1:0] enc_idx;
    logic         enc_any, accept;

`ifdef PRI_REQ_EDGE_EN
    // Tracks req every cycle, independent of enable, so edges are judged against the true prior level.
    logic [N-1:0] req_q;

    always_ff @(posedge clk) begin
        if (rst) req_q <= '0;
        else     req_q <= req;
    end

    assign sample = req & ~req_q;
`else
    assign sample = req;
`endif

    prio_enc_comb #(.N(N)) u_enc (
        .vec (pending),
        .idx (enc_idx),
        .any (enc_any)
    );

    assign accept       = (state == ST_PRESENT) && out_ready;
    assign cap          = enable ? sample : '0;
    assign clr          = accept ? N'(onehot(32'(out_idx))) : '0;
    assign pending_next = (pending & ~clr) | cap;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (enc_any) state_next = ST_PRESENT;
            ST_PRESENT: if (out_ready) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == ST_PRESENT);
    end

    // Grant index is chosen from the registered pending only; it is frozen while PRESENT.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            out_idx  <= '0;
            overflow <= 1'b0;
        end else begin
            pending  <= pending_next;
            overflow <= |(cap & pending & ~clr);
            if (state == ST_IDLE && enc_any)
                out_idx <= enc_idx;
        end
    end

endmodule

// File: tb/tb_pri_req_latch.sv
// Directed, table-driven bench for pri_req_latch plus a held-request sequence.
module tb_pri_req_latch;

    logic       clk = 1'b0;
    logic       rst, enable, out_ready;
    logic [3:0] req;
    logic       out_valid, overflow;
    logic [1:0] out_idx;
    logic [3:0] pending;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] req;
        logic       rdy;
        logic       ev;
        logic [1:0] eidx;
        logic [3:0] ep;
        logic       eo;
    } vec_t;

    vec_t tbl[$];

    pri_req_latch dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .req       (req),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .pending   (pending),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic e, input logic [3:0] q, input logic y,
                                input logic ev, input logic [1:0] ei, input logic [3:0] ep,
                                input logic eo);
        vec_t v;
        v.rst = r; v.en = e; v.req = q; v.rdy = y;
        v.ev = ev; v.eidx = ei; v.ep = ep; v.eo = eo;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    initial begin
        int grants;
        int bad_idx;

        rst = 1'b1; enable = 1'b1; req = 4'hF; out_ready = 1'b0;

        //   rst en req    rdy  valid idx pending ovf
        add(1, 1, 4'hF, 0,   0, 0, 4'h0, 0);   // reset held 2 clk with all req high
        add(1, 1, 4'hF, 0,   0, 0, 4'h0, 0);
        add(0, 1, 4'h5, 1,   0, 0, 4'h5, 0);   // 0101 pulse
        add(0, 1, 4'h0, 1,   1, 2, 4'h5, 0);
        add(0, 1, 4'h0, 1,   0, 2, 4'h1, 0);
        add(0, 1, 4'h0, 1,   1, 0, 4'h1, 0);
        add(0, 1, 4'h0, 1,   0, 0, 4'h0, 0);
        add(0, 1, 4'h2, 0,   0, 0, 4'h2, 0);   // present idx 1, stalled
        add(0, 1, 4'h0, 0,   1, 1, 4'h2, 0);
        add(0, 1, 4'h8, 0,   1, 1, 4'hA, 0);   // higher arrival must not preempt
        add(0, 1, 4'h0, 0,   1, 1, 4'hA, 0);
        add(0, 1, 4'h0, 1,   0, 1, 4'h8, 0);
        add(0, 1, 4'h0, 1,   1, 3, 4'h8, 0);
        add(0, 1, 4'h0, 1,   0, 3, 4'h0, 0);
        add(0, 1, 4'h2, 0,   0, 3, 4'h2, 0);   // set-wins-over-clear case
        add(0, 1, 4'h0, 0,   1, 1, 4'h2, 0);
        add(0, 1, 4'h2, 1,   0, 1, 4'h2, 0);
        add(0, 1, 4'h0, 0,   1, 1, 4'h2, 0);
        add(0, 1, 4'h2, 0,   1, 1, 4'h2, 1);   // re-request while pending -> overflow
        add(0, 1, 4'h0, 0,   1, 1, 4'h2, 0);
        add(0, 0, 4'hF, 0,   1, 1, 4'h2, 0);   // enable low: req ignored
        add(0, 0, 4'hF, 1,   0, 1, 4'h0, 0);
        add(0, 0, 4'h0, 1,   0, 1, 4'h0, 0);
        add(0, 1, 4'h4, 0,   0, 1, 4'h4, 0);   // reset mid-handshake
        add(0, 1, 4'h0, 0,   1, 2, 4'h4, 0);
        add(1, 1, 4'h0, 0,   0, 0, 4'h0, 0);
        add(0, 1, 4'h0, 0,   0, 0, 4'h0, 0);
        add(0, 1, 4'hF, 1,   0, 0, 4'hF, 0);   // all lines: descending grant order
        add(0, 1, 4'h0, 1,   1, 3, 4'hF, 0);
        add(0, 1, 4'h0, 1,   0, 3, 4'h7, 0);
        add(0, 1, 4'h0, 1,   1, 2, 4'h7, 0);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; enable = tbl[i].en; req = tbl[i].req; out_ready = tbl[i].rdy;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_valid", i),    32'(out_valid), 32'(tbl[i].ev));
            check($sformatf("v%0d_idx", i),      32'(out_idx),   32'(tbl[i].eidx));
            check($sformatf("v%0d_pending", i),  32'(pending),   32'(tbl[i].ep));
            check($sformatf("v%0d_overflow", i), 32'(overflow),  32'(tbl[i].eo));
        end

        // Held request: level mode re-grants every 2 clk, edge mode grants once.
        rst = 1'b1; req = 4'h0; enable = 1'b1; out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        grants = 0; bad_idx = 0;
        for (int k = 0; k < 16; k++) begin
            req = (k < 10) ? 4'h4 : 4'h0;
            @(posedge clk); @(negedge clk);
            if (out_valid && out_ready) begin
                grants++;
                if (out_idx != 2'd2) bad_idx++;
            end
        end
`ifdef PRI_REQ_EDGE_EN
        check("held_grants", 32'(grants), 32'd1);
`else
        check("held_grants", 32'(grants), 32'd5);
`endif
        check("held_idx_wrong", 32'(bad_idx), 32'd0);
        check("held_pending_end", 32'(pending), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
